// File: rtl/float_to_fixed_shift_ctrl.sv
// Control stage for the float-to-fixed linearizer: unpacks one IEEE-754
// operand, derives the barrel-shifter setup and sequences load/ready/ack.
module float_to_fixed_shift_ctrl #(
  parameter int W         = 32,
  parameter int EW        = 8,
  parameter int SW        = 23,
  parameter int SWR       = 26,
  parameter int EWR       = 5,
  parameter int BIAS      = 127,
  parameter int FIXED_EXP = 0,
  parameter int SHIFT_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           beg_op_i,
  input  logic [W-1:0]   float_i,
  input  logic           ack_i,
  output logic [SWR-1:0] shift_data_o,
  output logic [EWR-1:0] shift_value_o,
  output logic           left_right_o,
  output logic           bit_shift_o,
  output logic           load_o,
  output logic           sign_o,
  output logic           busy_o,
  output logic           ready_o,
  output logic           ovf_o,
  output logic           zero_o
);

  localparam int CW = (SHIFT_LAT < 1) ? 1 : $clog2(SHIFT_LAT + 1);
  localparam logic signed [EW+1:0] OFFSET = (EW+2)'(BIAS + FIXED_EXP);
  localparam logic        [EW+1:0] MAXD   = (EW+2)'(SWR - 1);
  localparam logic        [CW-1:0] LAST   = CW'(SHIFT_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_next;
  logic           r_load;
  logic           w_load_next;
  logic [W-1:0]   r_float;
  logic [SWR-1:0] r_data;
  logic [EWR-1:0] r_value;
  logic           r_lr;
  logic           r_sign;
  logic           r_ovf;
  logic           r_zero;

  // Operand unpacking and shift distance, evaluated from the latched operand
  logic [EW-1:0]          w_exp;
  logic [SW-1:0]          w_frac;
  logic signed [EW+1:0]   w_d;
  logic [EW+1:0]          w_mag;
  logic                   w_exp_zero;
  logic                   w_exp_ones;
  logic                   w_ovf;
  logic                   w_zero;
  logic                   w_valid;

  always_comb begin
    w_exp      = r_float[W-2 -: EW];
    w_frac     = r_float[SW-1:0];
    w_d        = $signed({2'b00, w_exp}) - OFFSET;
    w_mag      = w_d[EW+1] ? $unsigned(-w_d) : $unsigned(w_d);
    w_exp_zero = (w_exp == '0);
    w_exp_ones = (w_exp == '1);
    // Sign of d keeps the two range checks mutually exclusive
    w_ovf      = w_exp_ones | (!w_exp_zero && !w_d[EW+1] && (w_mag > MAXD));
    w_zero     = w_exp_zero | (!w_exp_ones &&  w_d[EW+1] && (w_mag > MAXD));
    w_valid    = !w_ovf && !w_zero;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (beg_op_i) w_state_next = CALC;
      end
      CALC: begin
        w_state_next = SHIFT;
        w_cnt_next   = '0;
      end
      SHIFT: begin
        // First SHIFT cycle lets the registered data settle; load then
        // stays high for SHIFT_LAT cycles.
        if (r_cnt == LAST) begin
          w_state_next = DONE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next  = r_cnt + 1'b1;
          w_load_next = 1'b1;
        end
      end
      DONE: begin
        if (ack_i) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_load  <= 1'b0;
      r_float <= '0;
      r_data  <= '0;
      r_value <= '0;
      r_lr    <= 1'b0;
      r_sign  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_load  <= w_load_next;
      if (r_state == IDLE && beg_op_i) r_float <= float_i;
      if (r_state == CALC) begin
        r_sign  <= r_float[W-1];
        r_ovf   <= w_ovf;
        r_zero  <= w_zero;
        r_data  <= w_valid ? {1'b1, w_frac, 2'b00} : '0;
        r_value <= w_valid ? w_mag[EWR-1:0] : '0;
        r_lr    <= w_valid && !w_d[EW+1];
      end
    end
  end

  assign shift_data_o  = r_data;
  assign shift_value_o = r_value;
  assign left_right_o  = r_lr;
  assign bit_shift_o   = 1'b0;
  assign load_o        = r_load;
  assign sign_o        = r_sign;
  assign busy_o        = (r_state != IDLE);
  assign ready_o       = (r_state == DONE);
  assign ovf_o         = r_ovf;
  assign zero_o        = r_zero;

endmodule

// File: tb/tb_float_to_fixed_shift_ctrl.sv
// Scoreboard bench for float_to_fixed_shift_ctrl with default parameters.
module tb_float_to_fixed_shift_ctrl;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        beg_op_i;
  logic [31:0] float_i;
  logic        ack_i;
  logic [25:0] shift_data_o;
  logic [4:0]  shift_value_o;
  logic        left_right_o;
  logic        bit_shift_o;
  logic        load_o;
  logic        sign_o;
  logic        busy_o;
  logic        ready_o;
  logic        ovf_o;
  logic        zero_o;

  float_to_fixed_shift_ctrl #(
    .W(32), .EW(8), .SW(23), .SWR(26), .EWR(5),
    .BIAS(127), .FIXED_EXP(0), .SHIFT_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .beg_op_i(beg_op_i), .float_i(float_i), .ack_i(ack_i),
    .shift_data_o(shift_data_o), .shift_value_o(shift_value_o),
    .left_right_o(left_right_o), .bit_shift_o(bit_shift_o), .load_o(load_o),
    .sign_o(sign_o), .busy_o(busy_o), .ready_o(ready_o), .ovf_o(ovf_o),
    .zero_o(zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [25:0] data;
    logic [4:0]  value;
    logic        lr;
    logic        sign;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t model(input logic [31:0] f);
    exp_t e;
    int   ex;
    int   d;
    e    = '0;
    ex   = int'(f[30:23]);
    d    = ex - 127;
    e.sign = f[31];
    if (ex == 0)        e.zero = 1'b1;
    else if (ex == 255) e.ovf  = 1'b1;
    else if (d > 25)    e.ovf  = 1'b1;
    else if (-d > 25)   e.zero = 1'b1;
    else begin
      e.data  = 26'h2000000 | (26'(f[22:0]) << 2);
      e.value = 5'((d < 0) ? -d : d);
      e.lr    = (d >= 0);
    end
    return e;
  endfunction

  task automatic start_op(input logic [31:0] f);
    @(negedge clk);
    beg_op_i = 1'b1;
    float_i  = f;
    sb_q.push_back(model(f));
    @(negedge clk);
    beg_op_i = 1'b0;
  endtask

  task automatic wait_ready(output int lat, output int loads);
    lat   = 0;
    loads = 0;
    while (!ready_o && lat < 50) begin
      if (load_o) loads++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({shift_data_o, shift_value_o, left_right_o, bit_shift_o, load_o, sign_o,
         busy_o, ready_o, ovf_o, zero_o} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h val=%0d busy=%b ready=%b load=%b want all zero",
               shift_data_o, shift_value_o, busy_o, ready_o, load_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_patterns();
    logic [31:0] vecs [12];
    exp_t e;
    int   lat;
    int   loads;
    vecs = '{32'h3F800000, 32'h40400000, 32'h3E800000, 32'hBF800000,
             32'h00000000, 32'h00000001, 32'h4E800000, 32'h7F800000,
             32'h4C000000, 32'h4C800000, 32'h33000000, 32'h32800000};
    foreach (vecs[i]) begin
      start_op(vecs[i]);
      wait_ready(lat, loads);
      e = sb_q.pop_front();
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL pat%0d_latency: got %0d want %0d", i, lat, LAT);
      end
      checks++;
      if (loads !== 2) begin
        errors++;
        $display("FAIL pat%0d_load_cycles: got %0d want 2", i, loads);
      end
      checks++;
      if ({shift_data_o, shift_value_o, sign_o, ovf_o, zero_o, bit_shift_o, load_o} !==
          {e.data, e.value, e.sign, e.ovf, e.zero, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL pat%0d_%h: got data=%h val=%0d s=%b ovf=%b zero=%b fill=%b load=%b want data=%h val=%0d s=%b ovf=%b zero=%b fill=0 load=0",
                 i, vecs[i], shift_data_o, shift_value_o, sign_o, ovf_o, zero_o, bit_shift_o,
                 load_o, e.data, e.value, e.sign, e.ovf, e.zero);
      end
      if (!e.ovf && !e.zero) begin
        checks++;
        if (left_right_o !== e.lr) begin
          errors++;
          $display("FAIL pat%0d_dir: got %b want %b", i, left_right_o, e.lr);
        end
      end
      checks++;
      if (ovf_o && zero_o) begin
        errors++;
        $display("FAIL pat%0d_flags_exclusive: got ovf=1 zero=1 want at most one", i);
      end
      do_ack();
    end
  endtask

  task automatic test_hold_ack();
    exp_t e;
    int   lat;
    int   loads;
    start_op(32'hC0400000);
    wait_ready(lat, loads);
    e = sb_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({ready_o, load_o, shift_data_o, shift_value_o, left_right_o, sign_o} !==
          {1'b1, 1'b0, e.data, e.value, e.lr, e.sign}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got rdy=%b load=%b data=%h val=%0d lr=%b s=%b want rdy=1 load=0 data=%h val=%0d lr=%b s=%b",
                 c, ready_o, load_o, shift_data_o, shift_value_o, left_right_o, sign_o,
                 e.data, e.value, e.lr, e.sign);
      end
      @(negedge clk);
    end
    do_ack();
    checks++;
    if ({busy_o, ready_o} !== 2'b00) begin
      errors++;
      $display("FAIL ack_to_idle: got busy=%b ready=%b want 0 0", busy_o, ready_o);
    end
  endtask

  task automatic test_ignore_beg();
    exp_t e;
    int   lat;
    int   loads;
    start_op(32'h3E800000);
    @(negedge clk);
    beg_op_i = 1'b1;
    float_i  = 32'h7F800000;
    @(negedge clk);
    beg_op_i = 1'b0;
    wait_ready(lat, loads);
    e = sb_q.pop_front();
    checks++;
    if (lat + 2 !== LAT) begin
      errors++;
      $display("FAIL busy_beg_latency: got %0d want %0d", lat + 2, LAT);
    end
    checks++;
    if ({ovf_o, zero_o, shift_value_o, left_right_o, shift_data_o} !==
        {e.ovf, e.zero, e.value, e.lr, e.data}) begin
      errors++;
      $display("FAIL busy_beg_ignored: got ovf=%b zero=%b val=%0d lr=%b data=%h want ovf=%b zero=%b val=%0d lr=%b data=%h",
               ovf_o, zero_o, shift_value_o, left_right_o, shift_data_o,
               e.ovf, e.zero, e.value, e.lr, e.data);
    end
    beg_op_i = 1'b1;
    ack_i    = 1'b1;
    float_i  = 32'h40400000;
    @(negedge clk);
    beg_op_i = 1'b0;
    ack_i    = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL done_beg_ack_idle: got busy=%b want 0", busy_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL done_beg_ignored: got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   lat;
    int   loads;
    bit   saw_ready;
    start_op(32'h3F800000);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy_o, load_o} !== 2'b11) begin
      errors++;
      $display("FAIL abort_in_shift: got busy=%b load=%b want 1 1", busy_o, load_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({shift_data_o, shift_value_o, left_right_o, bit_shift_o, load_o, sign_o,
         busy_o, ready_o, ovf_o, zero_o} !== 41'd0) begin
      errors++;
      $display("FAIL abort_outputs: got data=%h busy=%b load=%b ready=%b want all zero",
               shift_data_o, busy_o, load_o, ready_o);
    end
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    saw_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (ready_o || busy_o) saw_ready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_ready: got activity=%b want 0", saw_ready);
    end
    start_op(32'hBF800000);
    wait_ready(lat, loads);
    e = sb_q.pop_front();
    checks++;
    if ({lat, shift_data_o, shift_value_o, left_right_o, sign_o, ovf_o, zero_o} !==
        {LAT, e.data, e.value, e.lr, e.sign, e.ovf, e.zero}) begin
      errors++;
      $display("FAIL abort_recovery: got lat=%0d data=%h val=%0d lr=%b s=%b want lat=%0d data=%h val=%0d lr=%b s=%b",
               lat, shift_data_o, shift_value_o, left_right_o, sign_o,
               LAT, e.data, e.value, e.lr, e.sign);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          lat;
    int          loads;
    logic [31:0] f;
    for (int n = 0; n < 8; n++) begin
      f = {1'($urandom_range(0, 1)), 8'($urandom_range(98, 156)), 23'($urandom)};
      start_op(f);
      wait_ready(lat, loads);
      e = sb_q.pop_front();
      checks++;
      if ({lat, shift_data_o, shift_value_o, sign_o, ovf_o, zero_o} !==
          {LAT, e.data, e.value, e.sign, e.ovf, e.zero}) begin
        errors++;
        $display("FAIL b2b%0d_%h: got lat=%0d data=%h val=%0d s=%b ovf=%b zero=%b want lat=%0d data=%h val=%0d s=%b ovf=%b zero=%b",
                 n, f, lat, shift_data_o, shift_value_o, sign_o, ovf_o, zero_o,
                 LAT, e.data, e.value, e.sign, e.ovf, e.zero);
      end
      if (!e.ovf && !e.zero) begin
        checks++;
        if (left_right_o !== e.lr) begin
          errors++;
          $display("FAIL b2b%0d_dir: got %b want %b", n, left_right_o, e.lr);
        end
      end
      do_ack();
    end
  endtask

  initial begin
    beg_op_i = 1'b0;
    ack_i    = 1'b0;
    float_i  = '0;
    test_reset();
    test_patterns();
    test_hold_ack();
    test_ignore_beg();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
